// File: rtl/zsram_array.sv
// Register-based DATA_WIDTH x 2**ADDR_WIDTH RAM with independently strobed read and write ports.
// Asynchronous strobes are synchronised and edge-detected; write-first on same-address collisions.
module zsram_array #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  Crystal50Mhz1,
  input  logic                  Reset,
  input  logic                  WriteEdge,
  input  logic [ADDR_WIDTH-1:0] WriteAddress,
  input  logic [DATA_WIDTH-1:0] inputData,
  input  logic                  ReadEdge,
  input  logic [ADDR_WIDTH-1:0] ReadAddress,
  output logic [DATA_WIDTH-1:0] outputData,
  output logic                  WriteDone,
  output logic                  ReadValid,
  output logic                  Collision
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] rd_sync;
  logic                   wr_prev;
  logic                   rd_prev;
  logic                   wr_pulse;
  logic                   rd_pulse;
  logic                   same_addr;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  // Flops reset high so a strobe already high at reset release is not seen as a new edge.
  always_ff @(posedge Crystal50Mhz1 or posedge Reset) begin
    if (Reset) begin
      wr_sync <= '1;
      rd_sync <= '1;
      wr_prev <= 1'b1;
      rd_prev <= 1'b1;
    end else begin
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], WriteEdge};
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], ReadEdge};
      wr_prev <= wr_sync[SYNC_STAGES-1];
      rd_prev <= rd_sync[SYNC_STAGES-1];
    end
  end

  assign wr_pulse  = wr_sync[SYNC_STAGES-1] & ~wr_prev;
  assign rd_pulse  = rd_sync[SYNC_STAGES-1] & ~rd_prev;
  assign same_addr = (WriteAddress == ReadAddress);

  always_ff @(posedge Crystal50Mhz1 or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_pulse) begin
      mem[WriteAddress] <= inputData;
    end
  end

  // Read bypasses the word being written in the same cycle (write-first).
  always_ff @(posedge Crystal50Mhz1 or posedge Reset) begin
    if (Reset) begin
      outputData <= '0;
      WriteDone  <= 1'b0;
      ReadValid  <= 1'b0;
      Collision  <= 1'b0;
    end else begin
      WriteDone <= wr_pulse;
      ReadValid <= rd_pulse;
      Collision <= rd_pulse & wr_pulse & same_addr;
      if (rd_pulse) begin
        outputData <= (wr_pulse && same_addr) ? inputData : mem[ReadAddress];
      end
    end
  end

endmodule

// File: tb/tb_zsram_array.sv
// Scoreboard bench for zsram_array: directed strobe sequences push expected responses,
// a negedge monitor pops and compares them whenever WriteDone/ReadValid appear.
module tb_zsram_array;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned S  = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic          coll;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_edge;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_edge;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_done;
  logic          rd_valid;
  logic          coll;

  exp_t wq[$];
  exp_t rq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  zsram_array #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(S)) dut (
    .Crystal50Mhz1(clk),
    .Reset(rst),
    .WriteEdge(wr_edge),
    .WriteAddress(wr_addr),
    .inputData(wr_data),
    .ReadEdge(rd_edge),
    .ReadAddress(rd_addr),
    .outputData(rd_data),
    .WriteDone(wr_done),
    .ReadValid(rd_valid),
    .Collision(coll)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic lat_ok(int issued);
    int lat;
    lat = cyc - issued;
    return (lat >= int'(S) + 1) && (lat <= int'(S) + 3);
  endfunction

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (wr_done) begin
      if (wq.size() == 0) check("unexpected_write_done", 32'(wr_done), 32'd0);
      else begin
        e = wq.pop_front();
        check("write_done_latency", 32'(lat_ok(e.cyc)), 32'd1);
      end
    end
    if (rd_valid) begin
      if (rq.size() == 0) check("unexpected_read_valid", 32'(rd_valid), 32'd0);
      else begin
        e = rq.pop_front();
        check("read_data", 32'(rd_data), 32'(e.data));
        check("read_collision", 32'(coll), 32'(e.coll));
        check("read_valid_latency", 32'(lat_ok(e.cyc)), 32'd1);
      end
    end else if (coll) begin
      check("collision_without_valid", 32'(coll), 32'd0);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(string name);
    for (int i = 0; i < 20 && (wq.size() != 0 || rq.size() != 0); i++) tick(1);
    check(name, 32'(wq.size() + rq.size()), 32'd0);
    wq.delete();
    rq.delete();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold,
                          input int gap);
    wr_addr = a;
    wr_data = d;
    wq.push_back('{d, 1'b0, cyc});
    wr_edge = 1'b1;
    tick(hold);
    wait_drain("write_timeout");
    wr_edge = 1'b0;
    tick(gap);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd_addr = a;
    rq.push_back('{d, 1'b0, cyc});
    rd_edge = 1'b1;
    tick(1);
    wait_drain("read_timeout");
    rd_edge = 1'b0;
    tick(S + 2);
  endtask

  task automatic do_both(input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] ra, input logic [DW-1:0] rd, input logic c);
    wr_addr = wa;
    wr_data = wd;
    rd_addr = ra;
    wq.push_back('{wd, 1'b0, cyc});
    rq.push_back('{rd, c, cyc});
    wr_edge = 1'b1;
    rd_edge = 1'b1;
    tick(1);
    wait_drain("both_timeout");
    wr_edge = 1'b0;
    rd_edge = 1'b0;
    tick(S + 2);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    rst = 1'b1;
    wr_edge = 1'b0;
    rd_edge = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    tick(3);
    rst = 1'b0;
    tick(2);
    check("reset_output_data", 32'(rd_data), 32'd0);
    check("reset_write_done", 32'(wr_done), 32'd0);
    check("reset_read_valid", 32'(rd_valid), 32'd0);
    check("reset_collision", 32'(coll), 32'd0);

    // All words read back as zero after reset.
    for (int a = 0; a < 16; a++) do_read(AW'(a), 8'h00);

    // Basic write then read.
    do_write(4'd3, 8'hA5, 1, S + 2);
    do_read(4'd3, 8'hA5);

    // Simultaneous strobes on different addresses complete independently.
    do_both(4'd5, 8'h96, 4'd3, 8'hA5, 1'b0);
    do_read(4'd5, 8'h96);

    // Same-address collision: write-first with Collision flagged.
    do_write(4'd7, 8'h11, 1, S + 2);
    do_both(4'd7, 8'h3C, 4'd7, 8'h3C, 1'b1);
    do_read(4'd7, 8'h3C);

    // Held strobe yields exactly one write; re-arm after 3 low cycles.
    do_write(4'd9, 8'h5A, 20, 3);
    do_write(4'd9, 8'h5A, 20, S + 2);
    do_read(4'd9, 8'h5A);

    // Read strobe held across reset produces no read.
    rst = 1'b1;
    rd_edge = 1'b1;
    rd_addr = 4'd3;
    tick(3);
    rst = 1'b0;
    tick(10);
    check("held_read_no_valid", 32'(rd_valid), 32'd0);
    rd_edge = 1'b0;
    tick(S + 2);
    do_read(4'd3, 8'h00);

    // Reset right after the write commit cycle suppresses WriteDone and clears memory.
    do_write(4'd4, 8'h77, 1, S + 2);
    do_read(4'd4, 8'h77);
    wr_addr = 4'd2;
    wr_data = 8'hFF;
    wr_edge = 1'b1;
    tick(S + 1);
    rst = 1'b1;
    #1;
    check("midop_output_data", 32'(rd_data), 32'd0);
    check("midop_write_done", 32'(wr_done), 32'd0);
    check("midop_read_valid", 32'(rd_valid), 32'd0);
    wr_edge = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(S + 2);
    do_read(4'd2, 8'h00);
    do_read(4'd4, 8'h00);

    pulse_reset();
    wait_drain("final_drain");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
